// File: rtl/matrix_uart_pkg.sv
// Shared types and helpers for the matrix result UART link.
// Used by both the transmit path and the host-facing receiver.
package matrix_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      BYTE,
      FINISH
   } tx_state_t;

   localparam int WORD_W = 32;
   localparam int BYTES_PER_WORD = WORD_W / 8;

   function automatic int clks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/matrix_result_tx_if.sv
// Result-memory read port, start/status and serial line bundle.
// master = controller side, slave = matrix_result_tx.
interface matrix_result_tx_if #(
   parameter int MAX_M  = 4,
   parameter int MAX_P  = 4,
   parameter int DATA_W = 32
);
   localparam int MW = $clog2(MAX_M + 1);
   localparam int PW = $clog2(MAX_P + 1);
   localparam int RW = $clog2(MAX_M);
   localparam int CW = $clog2(MAX_P);

   logic              start;
   logic [MW-1:0]     m_dim;
   logic [PW-1:0]     p_dim;
   logic              rd_en;
   logic [RW-1:0]     rd_row;
   logic [CW-1:0]     rd_col;
   logic [DATA_W-1:0] rd_data;
   logic              uart_tx;
   logic              busy;
   logic              done;

   modport master (
      output start, m_dim, p_dim, rd_data,
      input  rd_en, rd_row, rd_col,
      input  uart_tx, busy, done
   );

   modport slave (
      input  start, m_dim, p_dim, rd_data,
      output rd_en, rd_row, rd_col,
      output uart_tx, busy, done
   );

endinterface

// File: rtl/matrix_result_tx_uart.sv
// 8N1 byte serializer; a new byte may be loaded in the
// last stop-bit cycle so consecutive bytes have no gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int CW = (CLKS_PER_BIT > 1) ?
                       $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    frame_q, frame_d;
   logic          busy_q, busy_d;
   logic          bit_end;
   logic          last;

   always_comb begin
      bit_end = busy_q &&
                (baud_q == CW'(CLKS_PER_BIT - 1));
      last    = bit_end && (bit_q == 4'd9);
      baud_d  = baud_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      busy_d  = busy_q;
      if (tx_start && (!busy_q || last)) begin
         frame_d = {1'b1, tx_data, 1'b0};
         baud_d  = '0;
         bit_d   = '0;
         busy_d  = 1'b1;
      end else if (bit_end) begin
         baud_d  = '0;
         frame_d = {1'b1, frame_q[9:1]};
         if (last) busy_d = 1'b0;
         else      bit_d  = bit_q + 4'd1;
      end else if (busy_q) begin
         baud_d = baud_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q  <= '0;
         bit_q   <= '0;
         frame_q <= '1;
         busy_q  <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
      end
   end

   assign tx      = busy_q ? frame_q[0] : 1'b1;
   assign tx_busy = busy_q;
   assign tx_done = last;

endmodule

// File: rtl/matrix_result_tx.sv
// Streams result matrix C row-major over UART, each word
// as bytes MSB first, two idle cycles between words.
module matrix_result_tx
   import matrix_uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int MAX_M      = 4,
   parameter int MAX_P      = 4,
   parameter int DATA_W     = WORD_W
) (
   input logic              clk,
   input logic              rst,
   matrix_result_tx_if.slave bus
);
   localparam int CLKS_PER_BIT =
      clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int NBYTES = DATA_W / 8;
   localparam int MW = $clog2(MAX_M + 1);
   localparam int PW = $clog2(MAX_P + 1);
   localparam int RW = $clog2(MAX_M);
   localparam int CW = $clog2(MAX_P);
   localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   tx_state_t         state_q, state_d;
   logic [MW-1:0]     m_q, m_d, m_cl;
   logic [PW-1:0]     p_q, p_d, p_cl;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [BW-1:0]     byte_q, byte_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx, tx_busy, tx_done;
   logic              last_row, last_col;

   always_comb begin
      m_cl = (bus.m_dim > MW'(MAX_M)) ?
             MW'(MAX_M) : bus.m_dim;
      p_cl = (bus.p_dim > PW'(MAX_P)) ?
             PW'(MAX_P) : bus.p_dim;
      last_row = (MW'(row_q) == m_q - 1'b1);
      last_col = (PW'(col_q) == p_q - 1'b1);
      state_d  = state_q;
      m_d      = m_q;
      p_d      = p_q;
      row_d    = row_q;
      col_d    = col_q;
      byte_d   = byte_q;
      word_d   = word_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rd_en    = 1'b0;
      tx_start = 1'b0;
      tx_data  = word_q[DATA_W-9 -: 8];
      unique case (state_q)
         IDLE: begin
            if (bus.start && !busy_q && !tx_busy) begin
               m_d    = m_cl;
               p_d    = p_cl;
               row_d  = '0;
               col_d  = '0;
               busy_d = 1'b1;
               if (m_cl == '0 || p_cl == '0)
                  state_d = FINISH;
               else
                  state_d = FETCH;
            end
         end
         FETCH: begin
            rd_en   = 1'b1;
            state_d = WAIT;
         end
         // first byte goes straight from the read port
         WAIT: begin
            word_d   = bus.rd_data;
            byte_d   = '0;
            tx_start = 1'b1;
            tx_data  = bus.rd_data[DATA_W-1 -: 8];
            state_d  = BYTE;
         end
         BYTE: begin
            if (tx_done) begin
               word_d = word_q << 8;
               if (byte_q == BW'(NBYTES - 1)) begin
                  if (last_col) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
                  if (last_col && last_row)
                     state_d = FINISH;
                  else
                     state_d = FETCH;
               end else begin
                  byte_d   = byte_q + 1'b1;
                  tx_start = 1'b1;
               end
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         byte_q  <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         row_q   <= row_d;
         col_q   <= col_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   assign bus.rd_en   = rd_en;
   assign bus.rd_row  = row_q;
   assign bus.rd_col  = col_q;
   assign bus.uart_tx = tx;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
